li_expander: RTL and testbench



---
 rtl/li_expander.sv | 143 ++++++++++++++
 tb/tb_li_expander.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/li_expander.sv
// li_expander: expands li/addi commands into RISC-V ADDI/LUI encodings
// and streams the words out over a valid/ready handshake.
module li_expander #(
  parameter int CNT_W      = 16,
  parameter bit NOP_ON_RD0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [4:0]       cmd_rd,
  input  logic [4:0]       cmd_rs1,
  input  logic [31:0]      cmd_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_last,
  output logic             err,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  state_t           state_q;
  logic [31:0]      inst_q;
  logic [31:0]      next_q;
  logic             last_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic        fits12;
  logic        rd0;
  logic        lo0;
  logic [11:0] lo;
  logic [19:0] hi;
  logic        emit_d;
  logic        bad_d;
  logic        last_d;
  logic [31:0] w1_d;
  logic [31:0] w2_d;

  // hi absorbs the sign of lo so LUI+ADDI reconstructs the constant
  always_comb begin
    fits12 = (&cmd_imm[31:11]) | ~(|cmd_imm[31:11]);
    rd0    = (cmd_rd == 5'd0);
    lo     = cmd_imm[11:0];
    lo0    = (lo == 12'd0);
    hi     = cmd_imm[31:12] + {19'd0, cmd_imm[11]};
    emit_d = 1'b0;
    bad_d  = 1'b0;
    last_d = 1'b1;
    w1_d   = 32'h0;
    w2_d   = {lo, cmd_rd, 3'b000, cmd_rd, 7'h13};
    unique case (1'b1)
      cmd_op & fits12: begin
        emit_d = 1'b1;
        w1_d   = {lo, cmd_rs1, 3'b000, cmd_rd, 7'h13};
      end
      cmd_op & ~fits12: begin
        bad_d = 1'b1;
      end
      ~cmd_op & rd0: begin
        emit_d = NOP_ON_RD0;
        w1_d   = 32'h0000_0013;
      end
      ~cmd_op & ~rd0 & fits12: begin
        emit_d = 1'b1;
        w1_d   = {lo, 5'd0, 3'b000, cmd_rd, 7'h13};
      end
      ~cmd_op & ~rd0 & ~fits12 & lo0: begin
        emit_d = 1'b1;
        w1_d   = {hi, cmd_rd, 7'h37};
      end
      ~cmd_op & ~rd0 & ~fits12 & ~lo0: begin
        emit_d = 1'b1;
        last_d = 1'b0;
        w1_d   = {hi, cmd_rd, 7'h37};
      end
      default: begin
        emit_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inst_q  <= 32'h0;
      next_q  <= 32'h0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            err_q <= bad_d;
            if (emit_d) begin
              inst_q  <= w1_d;
              last_q  <= last_d;
              next_q  <= w2_d;
              valid_q <= 1'b1;
              state_q <= EMIT1;
            end
          end
        end
        EMIT1: begin
          if (out_ready) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_q) begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              inst_q  <= next_q;
              last_q  <= 1'b1;
              state_q <= EMIT2;
            end
          end
        end
        EMIT2: begin
          if (out_ready) begin
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_last  = last_q;
  assign err       = err_q;
  assign inst_cnt  = cnt_q;

endmodule

// File: tb/tb_li_expander.sv
// tb_li_expander: directed checks of li/addi expansion, handshake,
// backpressure and asynchronous reset.
module tb_li_expander;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs1;
  logic [31:0] cmd_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        err;
  logic [15:0] inst_cnt;

  int n_cmp;
  int n_bad;

  li_expander #(.CNT_W(16), .NOP_ON_RD0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_imm(cmd_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_last(out_last),
    .err(err), .inst_cnt(inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one command for a single cycle; starts and ends at a negedge
  task automatic send(input logic op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [31:0] imm);
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // bounded wait for a word; out_ready must be 1 so it completes
  task automatic grab(output logic [31:0] w, output logic l,
                      output logic ok);
    ok = 1'b0;
    w  = 32'h0;
    l  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok && out_valid) begin
        w  = out_inst;
        l  = out_last;
        ok = 1'b1;
      end
      @(negedge clk);
      if (ok) break;
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({cmd_ready, out_valid, out_last, err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 1000",
               {cmd_ready, out_valid, out_last, err});
    end
    n_cmp++;
    if (out_inst !== 32'h0 || inst_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_vals got inst=%h cnt=%0d want 0/0",
               out_inst, inst_cnt);
    end
  endtask

  task automatic test_li_single;
    logic [31:0] w; logic l; logic ok;
    send(1'b0, 5'd5, 5'd0, 32'h0000_07FF);
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h7FF0_0293 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL li_7ff got %h last=%b ok=%b want 7ff00293 1",
               w, l, ok);
    end
    n_cmp++;
    if (inst_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL cnt_1 got %0d want 1", inst_cnt);
    end
    send(1'b0, 5'd5, 5'd0, 32'hFFFF_FFFF);
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'hFFF0_0293 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL li_neg1 got %h last=%b want fff00293 1", w, l);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_after got v=%b r=%b want 0 1",
               out_valid, cmd_ready);
    end
  endtask

  task automatic test_li_pair;
    logic [31:0] w; logic l; logic ok;
    send(1'b0, 5'd5, 5'd0, 32'h1234_5678);
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h1234_52B7 || l !== 1'b0) begin
      n_bad++;
      $display("FAIL pair_lui got %h last=%b want 123452b7 0", w, l);
    end
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h6782_8293 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL pair_addi got %h last=%b want 67828293 1", w, l);
    end
    n_cmp++;
    if (inst_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL cnt_4 got %0d want 4", inst_cnt);
    end
    send(1'b0, 5'd6, 5'd0, 32'h0000_0800);
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h0000_1337 || l !== 1'b0) begin
      n_bad++;
      $display("FAIL carry_lui got %h last=%b want 00001337 0", w, l);
    end
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h8003_0313 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL carry_addi got %h last=%b want 80030313 1", w, l);
    end
    send(1'b0, 5'd7, 5'd0, 32'hABCD_E000);
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'hABCD_E3B7 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL lui_only got %h last=%b want abcde3b7 1", w, l);
    end
    send(1'b0, 5'd5, 5'd0, 32'hFFFF_F800);
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h8000_0293 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL hi_wrap got %h last=%b want 80000293 1", w, l);
    end
    n_cmp++;
    if (inst_cnt !== 16'd8) begin
      n_bad++;
      $display("FAIL cnt_8 got %0d want 8", inst_cnt);
    end
  endtask

  task automatic test_addi;
    logic [31:0] w; logic l; logic ok;
    send(1'b1, 5'd1, 5'd2, 32'h0000_0800);
    n_cmp++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_err got err=%b v=%b want 1 0", err, out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({err, out_valid, cmd_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL err_pulse got %b want 001",
               {err, out_valid, cmd_ready});
    end
    send(1'b1, 5'd1, 5'd2, 32'hFFFF_F800);
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h8001_0093 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL addi_ok got %h last=%b want 80010093 1", w, l);
    end
    send(1'b1, 5'd3, 5'd4, 32'h0000_07FF);
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h7FF2_0193 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL addi_max got %h last=%b want 7ff20193 1", w, l);
    end
    send(1'b0, 5'd0, 5'd9, 32'h1234_5678);
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h0000_0013 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL rd0_nop got %h last=%b want 00000013 1", w, l);
    end
    n_cmp++;
    if (inst_cnt !== 16'd11) begin
      n_bad++;
      $display("FAIL cnt_11 got %0d want 11", inst_cnt);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w; logic l; logic ok;
    out_ready = 1'b0;
    send(1'b0, 5'd5, 5'd0, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid, out_last, cmd_ready} !== 3'b100 ||
          out_inst !== 32'h1234_52B7) begin
        n_bad++;
        $display("FAIL bp_hold%0d got %h v/l/r=%b want 123452b7 100",
                 i, out_inst, {out_valid, out_last, cmd_ready});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h1234_52B7 || l !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_first got %h last=%b want 123452b7 0", w, l);
    end
    grab(w, l, ok);
    n_cmp++;
    if (!ok || w !== 32'h6782_8293 || l !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_second got %h last=%b want 67828293 1", w, l);
    end
    n_cmp++;
    if (inst_cnt !== 16'd13) begin
      n_bad++;
      $display("FAIL cnt_13 got %0d want 13", inst_cnt);
    end
  endtask

  task automatic test_back_to_back;
    cmd_op    = 1'b0;
    cmd_rd    = 5'd5;
    cmd_rs1   = 5'd0;
    cmd_imm   = 32'h0000_07FF;
    cmd_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_busy got r=%b v=%b want 0 1",
               cmd_ready, out_valid);
    end
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (inst_cnt !== 16'd15) begin
      n_bad++;
      $display("FAIL b2b_cnt got %0d want 15", inst_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    out_ready = 1'b0;
    send(1'b0, 5'd5, 5'd0, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || inst_cnt !== 16'd0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid got v=%b cnt=%0d r=%b want 0 0 1",
               out_valid, inst_cnt, cmd_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0 || inst_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_no_word got words=%0d cnt=%0d want 0 0",
               seen, inst_cnt);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_rd    = 5'd0;
    cmd_rs1   = 5'd0;
    cmd_imm   = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_li_single;
    test_li_pair;
    test_addi;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
